// File: rtl/delay_line_param_pkg.sv
// ---------------------------------------------------------------------------
// delay_line_param_pkg
// Shared helpers and default widths for the parametrised pixel delay line.
//   clog2_safe : ceil(log2(n)) with a floor of 1, so single-entry buffers and
//                single-value selects still get a 1-bit field.
//   PTR_W      : pointer width for the default maximum depth.
//   SEL_W      : delay_sel width for the default maximum depth.
// ---------------------------------------------------------------------------
package delay_line_param_pkg;

    function automatic int clog2_safe(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_MAX_DEPTH = 16;
    localparam int PTR_W         = clog2_safe(DEF_MAX_DEPTH);
    localparam int SEL_W         = clog2_safe(DEF_MAX_DEPTH + 1);

endpackage

// File: rtl/delay_line_param_if.sv
// ---------------------------------------------------------------------------
// delay_line_param_if
// Stream-side bundle of the delay line.
//   per_clken  : sample enable, line advances only when 1
//   aclr       : synchronous flush
//   delay_sel  : requested delay in enabled cycles
//   din        : packed input, channel c at [c*DATA_W +: DATA_W]
//   dout       : registered delayed samples
//   dout_valid : dout updated by an enabled advance while primed
//   primed     : enough samples written for the current delay
// master = upstream driver / observer, slave = the delay line itself.
// ---------------------------------------------------------------------------
interface delay_line_param_if #(
    parameter int DATA_W    = 10,
    parameter int NUM_CH    = 1,
    parameter int MAX_DEPTH = 16
) ();
    import delay_line_param_pkg::*;

    localparam int SW = clog2_safe(MAX_DEPTH + 1);

    logic                     per_clken;
    logic                     aclr;
    logic [SW-1:0]            delay_sel;
    logic [NUM_CH*DATA_W-1:0] din;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     primed;

    modport master (
        output per_clken, aclr, delay_sel, din,
        input  dout, dout_valid, primed
    );

    modport slave (
        input  per_clken, aclr, delay_sel, din,
        output dout, dout_valid, primed
    );

endinterface

// File: rtl/delay_line_param_ctrl.sv
// ---------------------------------------------------------------------------
// delay_ctrl
// Shared control for all channels of the delay line: delay clamp, write
// pointer, read index, fill counter, delay-change detect, primed and
// dout_valid.
//   clk, rst        : clock, synchronous active-high reset
//   aclr            : synchronous flush (same effect as rst, lower priority)
//   per_clken       : sample enable
//   delay_sel       : requested delay, clamped to 1..MAX_DEPTH
//   flush           : rst or aclr this cycle
//   adv             : buffers write and dout registers update this cycle
//   bypass          : effective delay is 1, dout takes din directly
//   primed_next     : value primed takes on this edge (zero-fill select)
//   wr_ptr, rd_ptr  : buffer write / read indices
//   primed          : registered fill qualification
//   dout_valid      : registered output qualifier
// ---------------------------------------------------------------------------
module delay_ctrl
    import delay_line_param_pkg::*;
#(
    parameter  int MAX_DEPTH = 16,
    localparam int AW        = clog2_safe(MAX_DEPTH),
    localparam int SW        = clog2_safe(MAX_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          aclr,
    input  logic          per_clken,
    input  logic [SW-1:0] delay_sel,
    output logic          flush,
    output logic          adv,
    output logic          bypass,
    output logic          primed_next,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          primed,
    output logic          dout_valid
);

    logic [SW-1:0] d_eff;
    logic [SW-1:0] d_q;
    logic [SW-1:0] fill_cnt;
    logic [SW-1:0] fill_inc;
    logic [SW-1:0] fill_next;
    logic          chg;
    logic [SW:0]   wp_x;
    logic [SW:0]   dm1_x;
    logic [SW:0]   rd_x;

    always_comb begin
        d_eff = delay_sel;
        if (delay_sel == '0) begin
            d_eff = SW'(1);
        end else if (delay_sel > SW'(MAX_DEPTH)) begin
            d_eff = SW'(MAX_DEPTH);
        end
    end

    assign flush  = rst | aclr;
    assign adv    = per_clken & ~flush;
    assign bypass = (d_eff == SW'(1));

    // d_q holds last cycle's effective delay; any difference restarts the
    // output qualification without touching the buffer or pointer.
    assign chg = (d_eff != d_q);

    assign fill_inc = (fill_cnt == SW'(MAX_DEPTH)) ? fill_cnt : fill_cnt + SW'(1);

    always_comb begin
        fill_next   = fill_cnt;
        primed_next = primed;
        if (flush || chg) begin
            fill_next   = '0;
            primed_next = 1'b0;
        end else if (per_clken) begin
            fill_next   = fill_inc;
            primed_next = (fill_inc >= d_eff);
        end
    end

    // Read index = (wr_ptr - (D-1)) mod MAX_DEPTH with an explicit wrap, one
    // bit wider than the select so the add-back of MAX_DEPTH cannot overflow.
    always_comb begin
        wp_x  = (SW+1)'(wr_ptr);
        dm1_x = (SW+1)'(d_eff) - (SW+1)'(1);
        if (wp_x >= dm1_x) begin
            rd_x = wp_x - dm1_x;
        end else begin
            rd_x = wp_x + (SW+1)'(MAX_DEPTH) - dm1_x;
        end
        rd_ptr = AW'(rd_x);
    end

    always_ff @(posedge clk) begin
        d_q <= d_eff;
        if (flush) begin
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            primed     <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            fill_cnt   <= fill_next;
            primed     <= primed_next;
            dout_valid <= per_clken & primed_next;
            if (per_clken) begin
                wr_ptr <= (wr_ptr == AW'(MAX_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/delay_line_param.sv
// ---------------------------------------------------------------------------
// delay_line_param
// Clock-enabled, multi-channel pixel delay line with run-time delay select,
// synchronous flush, fill tracking and optional zero-fill while not primed.
// Equivalent to a D-stage shift register advanced by per_clken.
//   clk  : system clock
//   rst  : synchronous active-high reset (dominates aclr and per_clken)
//   bus  : slave side of delay_line_param_if (per_clken, aclr, delay_sel,
//          din in; dout, dout_valid, primed out)
// ---------------------------------------------------------------------------
module delay_line_param
    import delay_line_param_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int NUM_CH    = 1,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int ZERO_FILL = 1
) (
    input  logic               clk,
    input  logic               rst,
    delay_line_param_if.slave  bus
);

    localparam int AW = clog2_safe(MAX_DEPTH);

    logic                     flush;
    logic                     adv;
    logic                     bypass;
    logic                     primed_next;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [NUM_CH*DATA_W-1:0] dout_flat;

    delay_ctrl #(
        .MAX_DEPTH (MAX_DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .aclr        (bus.aclr),
        .per_clken   (bus.per_clken),
        .delay_sel   (bus.delay_sel),
        .flush       (flush),
        .adv         (adv),
        .bypass      (bypass),
        .primed_next (primed_next),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .primed      (bus.primed),
        .dout_valid  (bus.dout_valid)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [MAX_DEPTH];
        logic [DATA_W-1:0] din_c;
        logic [DATA_W-1:0] dly;
        logic [DATA_W-1:0] q;

        assign din_c = bus.din[c*DATA_W +: DATA_W];

        // Storage is never cleared; flush only resets pointers/qualifiers.
        always_ff @(posedge clk) begin
            if (adv) begin
                mem[wr_ptr] <= din_c;
            end
        end

        // With D=1 the read slot is the one being written this edge, so the
        // incoming sample is forwarded directly.
        always_comb begin
            dly = bypass ? din_c : mem[rd_ptr];
        end

        always_ff @(posedge clk) begin
            if (flush) begin
                q <= '0;
            end else if (adv) begin
                q <= ((ZERO_FILL != 0) && !primed_next) ? '0 : dly;
            end
        end

        assign dout_flat[c*DATA_W +: DATA_W] = q;
    end

    assign bus.dout = dout_flat;

endmodule

// File: tb/tb_delay_line_param.sv
// ---------------------------------------------------------------------------
// tb_delay_line_param
// Two instances: u_a (3 channels, depth 16, zero-fill) and u_b (1 channel,
// depth 12, no zero-fill). A behavioural shift-history model produces the
// expected outputs for each edge into a scoreboard queue; entries are popped
// and compared one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_delay_line_param;
    import delay_line_param_pkg::*;

    localparam int DW  = 10;
    localparam int NCA = 3;
    localparam int MDA = DEF_MAX_DEPTH;
    localparam int MDB = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delay_line_param_if #(.DATA_W(DW), .NUM_CH(NCA), .MAX_DEPTH(MDA)) bus_a ();
    delay_line_param_if #(.DATA_W(DW), .NUM_CH(1),   .MAX_DEPTH(MDB)) bus_b ();

    delay_line_param #(.DATA_W(DW), .NUM_CH(NCA), .MAX_DEPTH(MDA), .ZERO_FILL(1)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    delay_line_param #(.DATA_W(DW), .NUM_CH(1), .MAX_DEPTH(MDB), .ZERO_FILL(0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        int          m;
        logic [29:0] dout;
        logic        vld;
        logic        prm;
        bit          known;
    } exp_t;

    exp_t        sb [$];
    logic [29:0] hist0 [$];
    logic [29:0] hist1 [$];

    int          m_fill  [2];
    bit          m_prm   [2];
    bit          m_vld   [2];
    logic [29:0] m_dq    [2];
    bit          m_known [2];
    int          m_dprev [2];

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack(input int k);
        logic [9:0] c0, c1, c2;
        c0 = 10'(k % 641);
        c1 = 10'((32'h155 + k) & 32'h3FF);
        c2 = 10'((32'h3FF - k) & 32'h3FF);
        return {c2, c1, c0};
    endfunction

    // Ideal D-stage shift register, expressed as a history of written samples.
    task automatic model_step(input int m, input int maxd, input bit zf,
                              input bit r, input bit a, input bit e,
                              input int sel, input logic [29:0] d);
        int deff;
        bit chg;
        deff = (sel == 0) ? 1 : (sel > maxd) ? maxd : sel;
        chg  = (deff != m_dprev[m]);
        m_dprev[m] = deff;
        if (r || a) begin
            m_fill[m] = 0; m_prm[m] = 0; m_vld[m] = 0; m_dq[m] = '0; m_known[m] = 1;
        end else begin
            if (e) begin
                if (m == 0) begin
                    hist0.push_back(d);
                    if (hist0.size() > 40) void'(hist0.pop_front());
                end else begin
                    hist1.push_back(d);
                    if (hist1.size() > 40) void'(hist1.pop_front());
                end
            end
            if (chg) begin
                m_fill[m] = 0; m_prm[m] = 0;
            end else if (e) begin
                if (m_fill[m] < maxd) m_fill[m]++;
                m_prm[m] = (m_fill[m] >= deff);
            end
            m_vld[m] = e && m_prm[m];
            if (e) begin
                if (m_prm[m]) begin
                    m_dq[m]    = (m == 0) ? hist0[hist0.size() - deff] : hist1[hist1.size() - deff];
                    m_known[m] = 1;
                end else if (zf) begin
                    m_dq[m]    = '0;
                    m_known[m] = 1;
                end else begin
                    m_known[m] = 0;
                end
            end
        end
        sb.push_back('{m, m_dq[m], m_vld[m], m_prm[m], m_known[m]});
    endtask

    task automatic cycle(input bit r, input bit a, input bit e, input int sa, input int sbv,
                         input logic [29:0] da, input logic [9:0] db);
        exp_t x;
        rst             = r;
        bus_a.aclr      = a;
        bus_b.aclr      = a;
        bus_a.per_clken = e;
        bus_b.per_clken = e;
        bus_a.delay_sel = 5'(sa);
        bus_b.delay_sel = 4'(sbv);
        bus_a.din       = da;
        bus_b.din       = db;
        model_step(0, MDA, 1'b1, r, a, e, sa, da);
        model_step(1, MDB, 1'b0, r, a, e, sbv, {20'b0, db});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.m == 0) begin
                if (x.known) check("a_dout", 32'(bus_a.dout), 32'(x.dout));
                check("a_valid",  32'(bus_a.dout_valid), 32'(x.vld));
                check("a_primed", 32'(bus_a.primed),     32'(x.prm));
            end else begin
                if (x.known) check("b_dout", 32'(bus_b.dout), 32'(x.dout[9:0]));
                check("b_valid",  32'(bus_b.dout_valid), 32'(x.vld));
                check("b_primed", 32'(bus_b.primed),     32'(x.prm));
            end
        end
    endtask

    function automatic logic [9:0] bval(input int k);
        return 10'((k * 3) & 32'h3FF);
    endfunction

    initial begin
        int sa, sbv;
        bit e, a;
        m_dprev[0] = -1;
        m_dprev[1] = -1;

        // Reset, then ramp with D=8 across the 640 -> 0 wrap.
        cycle(1, 0, 1, 8, 8, pack(999), bval(999));
        cycle(1, 0, 1, 8, 8, pack(998), bval(998));
        check("reset_dout", 32'(bus_a.dout), 32'd0);
        check("reset_primed", 32'(bus_a.primed), 32'd0);
        for (int k = 0; k <= 700; k++) begin
            cycle(0, 0, 1, 8, 8, pack(n), bval(n));
            check("ramp_dout", 32'(bus_a.dout[9:0]), (k >= 7) ? 32'((k - 7) % 641) : 32'd0);
            check("ramp_primed", 32'(bus_a.primed), (k >= 7) ? 32'd1 : 32'd0);
            n++;
        end

        // Gated enable.
        for (int i = 0; i < 40; i++) begin
            e = (i % 2 == 0);
            cycle(0, 0, e, 8, 8, pack(n), bval(n));
            n++;
        end

        // Flush while primed and enabled; 300 must be discarded.
        cycle(0, 1, 1, 8, 8, {20'h0, 10'd300}, 10'd300);
        check("aclr_dout", 32'(bus_a.dout), 32'd0);
        check("aclr_primed", 32'(bus_a.primed), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 8, 8, pack(n), bval(n));
            n++;
        end

        // Clamp and delay change.
        for (int i = 0; i < 10; i++) begin cycle(0, 0, 1, 0, 8, pack(n), bval(n)); n++; end
        for (int i = 0; i < 12; i++) begin cycle(0, 0, 1, 3, 8, pack(n), bval(n)); n++; end
        for (int i = 0; i < 30; i++) begin cycle(0, 0, 1, 20, 15, pack(n), bval(n)); n++; end
        for (int i = 0; i < 20; i++) begin cycle(0, 0, 1, 4, 1, pack(n), bval(n)); n++; end

        // Random enables, occasional delay changes and flushes.
        sa  = 4;
        sbv = 5;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                sa  = int'($urandom_range(0, 20));
                sbv = int'($urandom_range(0, 15));
            end
            e = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 39) == 0);
            cycle(0, a, e, sa, sbv, 30'($urandom), 10'($urandom));
        end

        // rst and aclr together, then restart with D=8 on the non-zero-fill unit.
        cycle(1, 1, 1, 8, 8, pack(n), bval(n));
        check("dom_dout_b", 32'(bus_b.dout), 32'd0);
        check("dom_dout_a", 32'(bus_a.dout), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 0, 1, 8, 8, pack(n), bval(n));
            check("dom_valid_b", 32'(bus_b.dout_valid), (i >= 8) ? 32'd1 : 32'd0);
            n++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_param.md
Name: delay_line_param

Overview:
- Parametrised, clock-enabled, multi-channel pixel delay line.
- Successor to the fixed 8-stage delay used to align the Gaussian-filter A-path with the other pipeline branches.
- Adds run-time delay selection, channel packing, a synchronous flush, fill tracking and a zero-fill output mode.
- Sits between filter stages of the figure-recognition pipeline wherever one branch must be re-aligned to another.

Parameters:
- DATA_W, 10, bits per channel sample.
- NUM_CH, 1, number of parallel channels sharing one enable and one delay.
- MAX_DEPTH, 16, maximum delay in enabled cycles; must be at least 1.
- ZERO_FILL, 1, 1 = dout forced to 0 while not primed; 0 = dout shows buffer contents.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous active-high reset.
- per_clken  in  1  sample enable; the line advances only when this is 1.
- aclr  in  1  synchronous flush; acts on the clock edge and is not an asynchronous clear.
- delay_sel  in  $clog2(MAX_DEPTH+1)  requested delay D in enabled cycles.
- din  in  NUM_CH*DATA_W  packed input; channel c occupies bits [c*DATA_W +: DATA_W].
- dout  out  NUM_CH*DATA_W  delayed samples, registered.
- dout_valid  out  1  1 on the cycle dout was updated by an enabled advance and primed=1.
- primed  out  1  at least D samples have been written since the last clear or delay change.

Behaviour:
- Effective delay:
  - D = 1 if delay_sel = 0.
  - D = MAX_DEPTH if delay_sel > MAX_DEPTH.
  - Otherwise D = delay_sel.
- Equivalence:
  - Cycle-for-cycle equivalent to a D-stage shift register clocked by per_clken.
  - The sample taken on the k-th enabled edge appears on dout after the (k+D-1)-th enabled edge.
  - With per_clken held at 1 and D=8, din sampled at edge n is visible on dout after edge n+7, i.e. 8 registers deep.
  - D=1 gives dout <= din.
- per_clken = 0: dout, primed, pointers and the fill count all hold; dout_valid = 0.
- Storage:
  - Circular buffer of MAX_DEPTH entries per channel, with a wr_ptr that wraps from MAX_DEPTH-1 to 0.
  - Read index = (wr_ptr - (D-1)) mod MAX_DEPTH, computed with explicit wrap and no reliance on power-of-2 sizing.
- Fill counter:
  - fill_cnt saturates at MAX_DEPTH and increments on each enabled edge.
  - primed = (fill_cnt >= D), registered so it is coincident with the first valid dout.
- ZERO_FILL=1: while primed=0, dout is 0 on every advance.
- Delay change:
  - A change of D is detected as a registered compare with the previous D.
  - It clears fill_cnt and primed on the next edge.
  - Buffer contents are kept; only the output qualification restarts.
- Priority: rst > aclr > per_clken.
- rst or aclr:
  - Next edge sets wr_ptr=0, fill_cnt=0, primed=0, dout_valid=0, dout=0.
  - Buffer RAM need not be cleared.
  - If per_clken=1 on the same cycle, that sample is discarded.
- Reset mid-stream: the first sample after rst deasserts counts as sample 1.
- Reset values: dout=0, dout_valid=0, primed=0.
- All channels are identical and use the same pointers; there is no cross-channel arithmetic.

Decomposition:
- Shared package holds:
  - function clog2_safe, returning a minimum of 1;
  - localparam PTR_W = clog2_safe(MAX_DEPTH);
  - localparam SEL_W = clog2_safe(MAX_DEPTH+1).
- One sub-module, delay_ctrl: pointer, fill counter, D clamp, delay-change detect, primed and dout_valid.
- Top level instantiates delay_ctrl plus a generate loop of per-channel buffers.

Test Plan:
- Ramp, reset and fill:
  - Stimulus: DATA_W=10, NUM_CH=1, D=8, per_clken=1; din ramps 0..640 and wraps to 0; rst high 2 cycles then low.
  - Response: dout=0 and primed=0 for the first 7 edges; on the 8th edge dout=0 and primed=1; thereafter dout = din-7 each cycle.
  - Wrap check: after din 640 wraps to 0, dout shows 634..640 then 0.
- Gated enable:
  - Stimulus: same setup, per_clken toggles 1,0,1,0.
  - Response: dout changes only on enabled edges; dout_valid=0 on disabled cycles; delay measured in enabled samples (value 5 enters, exits 8 enables later).
- aclr flush:
  - Stimulus: aclr pulsed for 1 cycle while per_clken=1 and din=300, with stream primed.
  - Response: next edge dout=0 and primed=0; 300 is never output; re-primes after 8 further enables.
- Delay clamp and change:
  - Stimulus: delay_sel=0 first; later switch to 3; separately, delay_sel=20 with MAX_DEPTH=16.
  - Response: delay_sel=0 behaves as D=1 (dout = previous din); after the switch to 3, primed drops for 3 enables then dout = din-2; delay_sel=20 behaves as 16.
- Multi-channel independence:
  - Stimulus: NUM_CH=3, D=4, channels fed 0x000+n, 0x155+n, 0x3FF-n.
  - Response: each channel's dout matches its own input 4 enables earlier; no bit crossover.
- Reset dominance:
  - Stimulus: rst=1 and aclr=1 together mid-stream, then rst=0 with ZERO_FILL=0.
  - Response: all outputs 0 on the next edge; primed after D samples; dout_valid asserts exactly on the D-th enable.
